clyde_tk_sched: RTL and testbench
=================================

Name: clyde_tk_sched

Overview:
- Tweakey sequencer that sits directly downstream of phi_unit_dual and drives its control inputs.
- Supplies the tweak, consumes phi_out, and XORs it into share 0 of the masked key.
- Issues one round tweakey TK(s) per request from the masked Clyde round datapath, for s = 0..NSTEPS.
- Runs forward for encryption or backward for decryption.

Parameters:
- d, 2: number of key shares (masking order + 1).
- NSTEPS, 6: Clyde steps; NSTEPS+1 tweakeys are issued. NSTEPS mod 3 must be 0, because phi^3 = identity.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin a new schedule (accepted only in IDLE)
- inverse  in  1  direction, sampled with start: 0 = forward (phi), 1 = backward (phi^-1)
- tweak  in  128  tweak; held stable by the source from start until the first tk_valid
- key_sh  in  128*d  key shares, share i at [128*i +: 128]; held stable while busy
- busy  out  1  schedule in progress
- phi_in  out  128  to phi_unit_dual.phi_in; equals tweak
- phi_in_valid  out  1  to phi_unit_dual.phi_in_valid
- phi_inverse  out  1  to phi_unit_dual.inverse
- phi_enable  out  1  to phi_unit_dual.enable
- phi_out  in  128  from phi_unit_dual.phi_out
- tk_req  in  1  round datapath requests the next tweakey
- tk_valid  out  1  tk_sh holds a new tweakey (1-cycle pulse)
- tk_sh  out  128*d  masked tweakey shares
- tk_last  out  1  qualifies tk_valid: this is the final tweakey
- step_idx  out  3  step index of the tweakey on tk_sh
- done  out  1  1-cycle pulse, the cycle after the final tk_valid

Behaviour:
- FSM states: IDLE, ARMED, RUN, DONE.
- On rst, from any state including mid-schedule:
  - state goes to IDLE.
  - busy, tk_valid, tk_last, done, phi_enable, phi_in_valid and inverse_r are 0; tk_sh and step_idx are 0.
  - The phi register is not reset. Its content is irrelevant because ARMED always reloads it.
- IDLE: busy=0.
  - start=1: latch inverse_r<=inverse; step_idx <= 0 if forward, NSTEPS if inverse; go to ARMED.
  - tk_req is ignored in IDLE.
  - start and tk_req in the same cycle: start is taken, tk_req is dropped.
- ARMED: busy=1, phi_in_valid=1, so phi_out equals tweak combinationally.
  - tk_req=1 accepts the request. This is TK(0) forward or TK(NSTEPS) inverse, both equal to T.
  - On accept, assert phi_enable the same cycle, so phi register <= phi^{+/-1}(T). Then go to RUN.
- RUN: phi_in_valid=0; phi_out is the phi register.
  - Each tk_req accepts one request and asserts phi_enable combinationally that cycle.
  - If the accepted step is the last (step_idx==NSTEPS forward, or 0 inverse), go to DONE.
- Any state other than ARMED/RUN: phi_enable=0.
- DONE: done=1 for one cycle, busy=0, then go to IDLE. start is ignored in DONE.
- phi_inverse = inverse_r in all states.
- Accept (ARMED or RUN) in cycle n:
  - In cycle n+1: tk_sh share 0 = key_sh share 0 XOR phi_out(n); shares 1..d-1 = key_sh shares unchanged (registered).
  - In cycle n+1: tk_valid=1; step_idx reflects the issued step; tk_last=1 if it is the final step.
  - step_idx is then incremented (forward) or decremented (inverse).
- Latency: tk_req to tk_valid is exactly 1 cycle.
- tk_req held high in RUN issues one tweakey per cycle, back-to-back, with no bubbles.
- tk_req in DONE or IDLE is ignored.
- Exactly NSTEPS+1 tk_valid pulses occur per schedule.
- tk_sh holds its value between pulses.
- Forward issues phi^(s mod 3)(T) at step s. Inverse issues the same set in reverse order, which is correct because NSTEPS mod 3 = 0.
- No XOR across shares other than share 0. The unmasked tweak combines with share 0 only.

Test Plan:
- Forward, tweak=0, key_sh=0: start, then 7 single-cycle tk_reqs -> 7 tk_valid pulses, each one cycle after its req; every tk_sh=0; step_idx 0..6; tk_last on the 7th; done the following cycle.
- Forward, tweak=random T, share0=0xFF..FF, share1=K1: tk_sh share 0 equals ~phi^(s mod 3)(T), checked against the C phi model for s=0..6; share 1 equals K1 at every step.
- Inverse with the same T and key: the tk_sh sequence equals the forward sequence reversed; step_idx goes 6..0; phi_inverse=1 throughout.
- tk_req held high for 7 cycles from ARMED -> tk_valid high for 7 consecutive cycles, then done=1 for one cycle, busy=0.
- rst asserted in RUN after step 3 -> next cycle state IDLE and all outputs 0. A new start with a different T restarts at step_idx 0, and tk_sh share 0 = key share 0 XOR the new T.
- start asserted while busy, and tk_req asserted in IDLE -> no state change and no tk_valid.

Source files
------------

// File: rtl/clyde_tk_sched.sv
// Clyde tweakey sequencer: drives phi_unit_dual and issues TK(s) = key XOR phi^s(T) on share 0.
// Latency: tk_req to tk_valid is 1 cycle; back-to-back requests give one tweakey per cycle.
// Backpressure: none; tk_req is accepted only in ARMED/RUN and ignored in IDLE and DONE.
module clyde_tk_sched #(
   parameter int d      = 2,
   parameter int NSTEPS = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               inverse,
   input  logic [127:0]       tweak,
   input  logic [128*d-1:0]   key_sh,
   output logic               busy,
   output logic [127:0]       phi_in,
   output logic               phi_in_valid,
   output logic               phi_inverse,
   output logic               phi_enable,
   input  logic [127:0]       phi_out,
   input  logic               tk_req,
   output logic               tk_valid,
   output logic [128*d-1:0]   tk_sh,
   output logic               tk_last,
   output logic [2:0]         step_idx,
   output logic               done
);

   typedef enum logic [1:0] {IDLE, ARMED, RUN, DONE} state_t;

   localparam logic [2:0] LAST_STEP = 3'(NSTEPS);

   state_t     state;
   state_t     state_nxt;
   logic       inverse_r;
   logic [2:0] cnt;          // step that the next accepted request will issue
   logic       accept;
   logic       is_last;

   // The unmasked tweak only ever touches share 0; the other shares pass straight through.
   logic [128*d-1:0] tk_nxt;
   assign tk_nxt = key_sh ^ {{(128*(d-1)){1'b0}}, phi_out};

   assign is_last     = inverse_r ? (cnt == 3'd0) : (cnt == LAST_STEP);
   assign phi_in      = tweak;
   assign phi_inverse = inverse_r;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and control outputs; phi_enable fires in the same cycle a request is accepted.
   always_comb begin
      state_nxt    = state;
      busy         = 1'b0;
      phi_in_valid = 1'b0;
      phi_enable   = 1'b0;
      accept       = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = ARMED;
            end
         end
         ARMED: begin
            // phi unit bypasses its register so phi_out is the raw tweak for the first tweakey.
            busy         = 1'b1;
            phi_in_valid = 1'b1;
            if (tk_req) begin
               accept     = 1'b1;
               phi_enable = 1'b1;
               state_nxt  = is_last ? DONE : RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (tk_req) begin
               accept     = 1'b1;
               phi_enable = 1'b1;
               state_nxt  = is_last ? DONE : RUN;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Direction/step bookkeeping and the registered tweakey output.
   always_ff @(posedge clk) begin
      if (rst) begin
         inverse_r <= 1'b0;
         cnt       <= 3'd0;
         step_idx  <= 3'd0;
         tk_sh     <= '0;
         tk_valid  <= 1'b0;
         tk_last   <= 1'b0;
         done      <= 1'b0;
      end else begin
         tk_valid <= accept;
         tk_last  <= accept && is_last;
         // DONE coincides with the final tk_valid, so done lands one cycle later.
         done     <= (state == DONE);
         if (state == IDLE && start) begin
            inverse_r <= inverse;
            cnt       <= inverse ? LAST_STEP : 3'd0;
            step_idx  <= inverse ? LAST_STEP : 3'd0;
         end else if (accept) begin
            tk_sh    <= tk_nxt;
            step_idx <= cnt;
            cnt      <= inverse_r ? (cnt - 3'd1) : (cnt + 3'd1);
         end
      end
   end

endmodule

// File: tb/tb_clyde_tk_sched.sv
// Directed bench for clyde_tk_sched with a behavioural phi_unit_dual model.
// Stimulus is driven 1 ns after the rising edge and outputs are sampled there too.
// Expected tweakeys come from an independent order-3 phi model: phi(a,b) = (a^b, a).
module tb_clyde_tk_sched;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic         inverse;
   logic [127:0] tweak;
   logic [255:0] key_sh;
   logic         busy;
   logic [127:0] phi_in;
   logic         phi_in_valid;
   logic         phi_inverse;
   logic         phi_enable;
   logic [127:0] phi_out;
   logic         tk_req;
   logic         tk_valid;
   logic [255:0] tk_sh;
   logic         tk_last;
   logic [2:0]   step_idx;
   logic         done;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   clyde_tk_sched #(.d(2), .NSTEPS(6)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .inverse      (inverse),
      .tweak        (tweak),
      .key_sh       (key_sh),
      .busy         (busy),
      .phi_in       (phi_in),
      .phi_in_valid (phi_in_valid),
      .phi_inverse  (phi_inverse),
      .phi_enable   (phi_enable),
      .phi_out      (phi_out),
      .tk_req       (tk_req),
      .tk_valid     (tk_valid),
      .tk_sh        (tk_sh),
      .tk_last      (tk_last),
      .step_idx     (step_idx),
      .done         (done)
   );

   function automatic logic [127:0] phi_f(input logic [127:0] x);
      return {x[127:64] ^ x[63:0], x[127:64]};
   endfunction

   function automatic logic [127:0] phi_inv_f(input logic [127:0] x);
      return {x[63:0], x[127:64] ^ x[63:0]};
   endfunction

   function automatic logic [127:0] phi_pow(input logic [127:0] t, input int n);
      logic [127:0] r = t;
      for (int i = 0; i < n; i++) r = phi_f(r);
      return r;
   endfunction

   function automatic logic [255:0] exp_tk(input logic [127:0] t, input logic [255:0] k, input int s);
      return k ^ {128'b0, phi_pow(t, s % 3)};
   endfunction

   // phi_unit_dual model: bypass on phi_in_valid, otherwise the stepped register.
   logic [127:0] phi_reg;
   assign phi_out = phi_in_valid ? phi_in : phi_reg;
   always @(posedge clk) begin
      if (phi_enable) phi_reg <= phi_inverse ? phi_inv_f(phi_out) : phi_f(phi_out);
   end

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic accept_one(input int s, input logic [255:0] exp_sh, input bit last, input bit hold);
      tk_req = 1'b1;
      #0;
      chk("phi_enable", phi_enable, 1);
      tick();
      if (!hold) tk_req = 1'b0;
      chk("tk_valid", tk_valid, 1);
      chk("step_idx", step_idx, s);
      chk("tk_last", tk_last, last);
      chk("tk_sh", tk_sh, exp_sh);
   endtask

   task automatic run_sched(input logic inv, input logic [127:0] t, input logic [255:0] k, input bit hold);
      int s;
      int prev;
      tweak = t; key_sh = k; inverse = inv; start = 1'b1;
      tick();
      start = 1'b0; inverse = 1'b0;
      chk("armed_busy", busy, 1);
      chk("armed_pvalid", phi_in_valid, 1);
      chk("phi_inverse", phi_inverse, inv);
      chk("armed_step", step_idx, inv ? 6 : 0);
      prev = 0;
      for (int i = 0; i <= 6; i++) begin
         s = inv ? 6 - i : i;
         if (!hold && i > 0) begin
            tick();
            chk("gap_valid", tk_valid, 0);
            chk("gap_hold", tk_sh, exp_tk(t, k, prev));
            chk("run_pvalid", phi_in_valid, 0);
            chk("run_inverse", phi_inverse, inv);
         end
         accept_one(s, exp_tk(t, k, s), i == 6, hold);
         prev = s;
      end
      tk_req = 1'b0;
      chk("done_early", done, 0);
      tick();
      chk("done_pulse", done, 1);
      chk("done_busy", busy, 0);
      chk("done_valid", tk_valid, 0);
      tick();
      chk("done_clear", done, 0);
      chk("tk_sh_hold", tk_sh, exp_tk(t, k, inv ? 0 : 6));
   endtask

   localparam logic [127:0] T1 = 128'h0123456789abcdef_fedcba9876543210;
   localparam logic [127:0] T2 = 128'hdeadbeefcafef00d_1122334455667788;
   localparam logic [127:0] K1 = 128'h0f1e2d3c4b5a6978_8796a5b4c3d2e1f0;
   localparam logic [255:0] KA = {K1, {128{1'b1}}};
   localparam logic [255:0] KB = {128'h55aa55aa_33cc33cc_0ff00ff0_a5a5a5a5,
                                  128'h13579bdf_2468ace0_fedcba98_01234567};

   initial begin
      rst = 1'b1; start = 1'b0; inverse = 1'b0; tweak = '0; key_sh = '0; tk_req = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      chk("rst_busy", busy, 0);
      chk("rst_valid", tk_valid, 0);
      chk("rst_done", done, 0);
      chk("rst_tk_sh", tk_sh, 0);
      chk("rst_step", step_idx, 0);
      chk("rst_pvalid", phi_in_valid, 0);

      // All-zero tweak and key: every tweakey is zero.
      run_sched(1'b0, 128'b0, 256'b0, 1'b0);
      // Forward and inverse with non-trivial tweak and key.
      run_sched(1'b0, T1, KA, 1'b0);
      run_sched(1'b1, T1, KA, 1'b0);
      // tk_req held high: seven consecutive tweakeys.
      run_sched(1'b0, T2, KB, 1'b1);
      run_sched(1'b1, T2, KB, 1'b1);

      // Reset in the middle of an inverse schedule.
      tweak = T1; key_sh = KB; inverse = 1'b1; start = 1'b1;
      tick();
      start = 1'b0; inverse = 1'b0;
      for (int s = 6; s >= 3; s--) accept_one(s, exp_tk(T1, KB, s), 1'b0, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_valid", tk_valid, 0);
      chk("mid_rst_tk_sh", tk_sh, 0);
      chk("mid_rst_step", step_idx, 0);
      chk("mid_rst_inv", phi_inverse, 0);
      chk("mid_rst_pvalid", phi_in_valid, 0);

      // tk_req in IDLE is ignored.
      tk_req = 1'b1;
      #0;
      chk("idle_phi_en", phi_enable, 0);
      tick();
      chk("idle_req_valid", tk_valid, 0);
      chk("idle_req_busy", busy, 0);
      // start and tk_req together: start wins, request is dropped.
      tweak = T2; start = 1'b1;
      tick();
      start = 1'b0; tk_req = 1'b0;
      chk("both_busy", busy, 1);
      chk("both_valid", tk_valid, 0);
      chk("both_pvalid", phi_in_valid, 1);
      // start while busy must not re-latch the direction.
      start = 1'b1; inverse = 1'b1;
      tick();
      start = 1'b0; inverse = 1'b0;
      chk("rebusy_inv", phi_inverse, 0);
      chk("rebusy_pvalid", phi_in_valid, 1);
      chk("rebusy_step", step_idx, 0);
      chk("rebusy_valid", tk_valid, 0);
      // Restart after reset issues from step 0 with the new tweak.
      for (int s = 0; s <= 6; s++) accept_one(s, exp_tk(T2, KB, s), s == 6, 1'b0);
      tick();
      chk("restart_done", done, 1);
      chk("restart_busy", busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
